// File: rtl/rs_ex_unit.sv
// rs_ex_unit: RS-fed execution stage; one ALU/branch/jump result per cycle on the RS-EX result bus.
// Define RS_EX_RV32M_EN to add the RV32M multiplier and a 33-cycle restoring divider that stalls the RS.
//
// state | meaning
// IDLE  | accepting issues; single-cycle results broadcast the cycle after issue
// DIV   | one restoring shift-subtract step per cycle, RS stalled
// FIN   | sign fix-up and broadcast of the divide result
module rs_ex_unit #(
    parameter int OPNUM_W  = 6,
    parameter int ROB_ID_W = 4,
    parameter int XLEN     = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic [OPNUM_W-1:0]  opnum_from_rs,
    input  logic [XLEN-1:0]     V1_from_rs,
    input  logic [XLEN-1:0]     V2_from_rs,
    input  logic [XLEN-1:0]     pc_from_rs,
    input  logic [XLEN-1:0]     imm_from_rs,
    input  logic [ROB_ID_W-1:0] rob_id_from_rs,
    input  logic                rollback_sign_from_rob,
    output logic                valid_sign_to_cdb,
    output logic [ROB_ID_W-1:0] rob_id_to_cdb,
    output logic [XLEN-1:0]     data_to_cdb,
    output logic                jump_sign_to_rob,
    output logic [XLEN-1:0]     target_pc_to_rob,
    output logic                stall_sign_to_rs
);
    localparam logic [ROB_ID_W-1:0] INVALID_ROB = '0;
    localparam int SH_W = $clog2(XLEN);

    localparam logic [OPNUM_W-1:0]
        OP_NULL  = OPNUM_W'(0),  OP_LUI   = OPNUM_W'(1),  OP_AUIPC = OPNUM_W'(2),
        OP_JAL   = OPNUM_W'(3),  OP_JALR  = OPNUM_W'(4),  OP_BEQ   = OPNUM_W'(5),
        OP_BNE   = OPNUM_W'(6),  OP_BLT   = OPNUM_W'(7),  OP_BGE   = OPNUM_W'(8),
        OP_BLTU  = OPNUM_W'(9),  OP_BGEU  = OPNUM_W'(10), OP_ADDI  = OPNUM_W'(19),
        OP_SLTI  = OPNUM_W'(20), OP_SLTIU = OPNUM_W'(21), OP_XORI  = OPNUM_W'(22),
        OP_ORI   = OPNUM_W'(23), OP_ANDI  = OPNUM_W'(24), OP_SLLI  = OPNUM_W'(25),
        OP_SRLI  = OPNUM_W'(26), OP_SRAI  = OPNUM_W'(27), OP_ADD   = OPNUM_W'(28),
        OP_SUB   = OPNUM_W'(29), OP_SLL   = OPNUM_W'(30), OP_SLT   = OPNUM_W'(31),
        OP_SLTU  = OPNUM_W'(32), OP_XOR   = OPNUM_W'(33), OP_SRL   = OPNUM_W'(34),
        OP_SRA   = OPNUM_W'(35), OP_OR    = OPNUM_W'(36), OP_AND   = OPNUM_W'(37);

    logic [XLEN-1:0] pc_plus4, pc_plus_imm, op2;
    logic [XLEN-1:0] alu_data, alu_target;
    logic            alu_jump, is_branch;
    logic [SH_W-1:0] shamt;

    assign pc_plus4    = pc_from_rs + XLEN'(4);
    assign pc_plus_imm = pc_from_rs + imm_from_rs;
    assign op2   = (opnum_from_rs inside {[OP_ADDI:OP_SRAI]}) ? imm_from_rs : V2_from_rs;
    assign shamt = op2[SH_W-1:0];

`ifdef RS_EX_RV32M_EN
    localparam logic [OPNUM_W-1:0]
        OP_MUL  = OPNUM_W'(38), OP_MULH = OPNUM_W'(39), OP_MULHSU = OPNUM_W'(40),
        OP_MULHU = OPNUM_W'(41), OP_DIV = OPNUM_W'(42), OP_DIVU   = OPNUM_W'(43),
        OP_REM  = OPNUM_W'(44), OP_REMU = OPNUM_W'(45);
    localparam int CNT_W = $clog2(XLEN);

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_FIN} state_t;
    state_t state;

    // Sign-extend per operand as needed; the low 2*XLEN bits of the product are exact for all forms.
    logic              mul_a_sgn, mul_b_sgn, is_div, div_sgn, s1, s2;
    logic [2*XLEN-1:0] mul_a, mul_b, mul_prod;
    assign mul_a_sgn = (opnum_from_rs == OP_MULH) || (opnum_from_rs == OP_MULHSU);
    assign mul_b_sgn = (opnum_from_rs == OP_MULH);
    assign mul_a     = {{XLEN{mul_a_sgn & V1_from_rs[XLEN-1]}}, V1_from_rs};
    assign mul_b     = {{XLEN{mul_b_sgn & V2_from_rs[XLEN-1]}}, V2_from_rs};
    assign mul_prod  = mul_a * mul_b;
    assign is_div    = opnum_from_rs inside {[OP_DIV:OP_REMU]};
    assign div_sgn   = (opnum_from_rs == OP_DIV) || (opnum_from_rs == OP_REM);
    assign s1        = div_sgn & V1_from_rs[XLEN-1];
    assign s2        = div_sgn & V2_from_rs[XLEN-1];

    // Dividend magnitude lives in div_quo and shifts out MSB-first as quotient bits shift in.
    logic [XLEN-1:0]     div_quo, div_rem, div_dvs, div_next_pc, q_fix, r_fix;
    logic [XLEN:0]       rem_shift, rem_sub;
    logic                div_neg_q, div_neg_r, div_zero, div_is_rem;
    logic [ROB_ID_W-1:0] div_rob;
    logic [CNT_W-1:0]    div_cnt;

    assign rem_shift = {div_rem, div_quo[XLEN-1]};
    assign rem_sub   = rem_shift - {1'b0, div_dvs};
    assign q_fix     = div_zero ? '1 : (div_neg_q ? -div_quo : div_quo);
    assign r_fix     = div_neg_r ? -div_rem : div_rem;
    assign stall_sign_to_rs = (state != S_IDLE);
`else
    assign stall_sign_to_rs = 1'b0;
`endif

    always_comb begin
        alu_data   = '0;
        alu_jump   = 1'b0;
        alu_target = pc_plus4;
        is_branch  = 1'b0;
        case (opnum_from_rs)
            OP_LUI:   alu_data = imm_from_rs;
            OP_AUIPC: alu_data = pc_plus_imm;
            OP_JAL: begin
                alu_data   = pc_plus4;
                alu_jump   = 1'b1;
                alu_target = pc_plus_imm;
            end
            OP_JALR: begin
                alu_data   = pc_plus4;
                alu_jump   = 1'b1;
                alu_target = (V1_from_rs + imm_from_rs) & ~XLEN'(1);
            end
            OP_BEQ:  begin is_branch = 1'b1; alu_jump = (V1_from_rs == V2_from_rs); end
            OP_BNE:  begin is_branch = 1'b1; alu_jump = (V1_from_rs != V2_from_rs); end
            OP_BLT:  begin is_branch = 1'b1; alu_jump = ($signed(V1_from_rs) < $signed(V2_from_rs)); end
            OP_BGE:  begin is_branch = 1'b1; alu_jump = ($signed(V1_from_rs) >= $signed(V2_from_rs)); end
            OP_BLTU: begin is_branch = 1'b1; alu_jump = (V1_from_rs < V2_from_rs); end
            OP_BGEU: begin is_branch = 1'b1; alu_jump = (V1_from_rs >= V2_from_rs); end
            OP_ADD, OP_ADDI:   alu_data = V1_from_rs + op2;
            OP_SUB:            alu_data = V1_from_rs - op2;
            OP_AND, OP_ANDI:   alu_data = V1_from_rs & op2;
            OP_OR, OP_ORI:     alu_data = V1_from_rs | op2;
            OP_XOR, OP_XORI:   alu_data = V1_from_rs ^ op2;
            OP_SLT, OP_SLTI:   alu_data = XLEN'($signed(V1_from_rs) < $signed(op2));
            OP_SLTU, OP_SLTIU: alu_data = XLEN'(V1_from_rs < op2);
            OP_SLL, OP_SLLI:   alu_data = V1_from_rs << shamt;
            OP_SRL, OP_SRLI:   alu_data = V1_from_rs >> shamt;
            OP_SRA, OP_SRAI:   alu_data = $signed(V1_from_rs) >>> shamt;
`ifdef RS_EX_RV32M_EN
            OP_MUL:                        alu_data = mul_prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  alu_data = mul_prod[2*XLEN-1:XLEN];
`endif
            default: ;
        endcase
        if (is_branch && alu_jump)
            alu_target = pc_plus_imm;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_sign_to_cdb <= 1'b0;
            rob_id_to_cdb     <= INVALID_ROB;
            data_to_cdb       <= '0;
            jump_sign_to_rob  <= 1'b0;
            target_pc_to_rob  <= '0;
`ifdef RS_EX_RV32M_EN
            state       <= S_IDLE;
            div_quo     <= '0;
            div_rem     <= '0;
            div_dvs     <= '0;
            div_next_pc <= '0;
            div_neg_q   <= 1'b0;
            div_neg_r   <= 1'b0;
            div_zero    <= 1'b0;
            div_is_rem  <= 1'b0;
            div_rob     <= INVALID_ROB;
            div_cnt     <= '0;
`endif
        end else if (rdy) begin
            valid_sign_to_cdb <= 1'b0;
            rob_id_to_cdb     <= INVALID_ROB;
            if (rollback_sign_from_rob) begin
`ifdef RS_EX_RV32M_EN
                state <= S_IDLE;
`endif
            end else begin
`ifdef RS_EX_RV32M_EN
                case (state)
                    S_IDLE: begin
                        if (opnum_from_rs != OP_NULL) begin
                            if (is_div) begin
                                div_quo     <= s1 ? -V1_from_rs : V1_from_rs;
                                div_dvs     <= s2 ? -V2_from_rs : V2_from_rs;
                                div_rem     <= '0;
                                div_neg_q   <= s1 ^ s2;
                                div_neg_r   <= s1;
                                div_zero    <= (V2_from_rs == '0);
                                div_is_rem  <= (opnum_from_rs == OP_REM) || (opnum_from_rs == OP_REMU);
                                div_rob     <= rob_id_from_rs;
                                div_next_pc <= pc_plus4;
                                div_cnt     <= CNT_W'(XLEN - 1);
                                state       <= S_DIV;
                            end else begin
                                valid_sign_to_cdb <= 1'b1;
                                rob_id_to_cdb     <= rob_id_from_rs;
                                data_to_cdb       <= alu_data;
                                jump_sign_to_rob  <= alu_jump;
                                target_pc_to_rob  <= alu_target;
                            end
                        end
                    end
                    S_DIV: begin
                        if (!rem_sub[XLEN]) begin
                            div_rem <= rem_sub[XLEN-1:0];
                            div_quo <= {div_quo[XLEN-2:0], 1'b1};
                        end else begin
                            div_rem <= rem_shift[XLEN-1:0];
                            div_quo <= {div_quo[XLEN-2:0], 1'b0};
                        end
                        div_cnt <= div_cnt - 1'b1;
                        if (div_cnt == '0)
                            state <= S_FIN;
                    end
                    S_FIN: begin
                        valid_sign_to_cdb <= 1'b1;
                        rob_id_to_cdb     <= div_rob;
                        data_to_cdb       <= div_is_rem ? r_fix : q_fix;
                        jump_sign_to_rob  <= 1'b0;
                        target_pc_to_rob  <= div_next_pc;
                        state             <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
`else
                if (opnum_from_rs != OP_NULL) begin
                    valid_sign_to_cdb <= 1'b1;
                    rob_id_to_cdb     <= rob_id_from_rs;
                    data_to_cdb       <= alu_data;
                    jump_sign_to_rob  <= alu_jump;
                    target_pc_to_rob  <= alu_target;
                end
`endif
            end
        end
    end
endmodule

// File: tb/tb_rs_ex_unit.sv
// Directed self-checking bench for rs_ex_unit; the RV32M section follows RS_EX_RV32M_EN.
module tb_rs_ex_unit;
    localparam logic [5:0]
        OP_NULL = 6'd0,  OP_LUI  = 6'd1,  OP_AUIPC = 6'd2,  OP_JAL   = 6'd3,  OP_JALR = 6'd4,
        OP_BEQ  = 6'd5,  OP_BNE  = 6'd6,  OP_BLT   = 6'd7,  OP_BGE   = 6'd8,  OP_BLTU = 6'd9,
        OP_BGEU = 6'd10, OP_SLTIU = 6'd21, OP_XORI = 6'd22, OP_SRAI  = 6'd27, OP_ADD  = 6'd28,
        OP_SUB  = 6'd29, OP_SLL  = 6'd30, OP_SLT   = 6'd31, OP_SLTU  = 6'd32, OP_SRL  = 6'd34,
        OP_OR   = 6'd36, OP_AND  = 6'd37, OP_MUL   = 6'd38, OP_MULH  = 6'd39, OP_MULHSU = 6'd40,
        OP_MULHU = 6'd41, OP_DIV = 6'd42, OP_DIVU  = 6'd43, OP_REM   = 6'd44, OP_REMU = 6'd45;

    logic        clk = 1'b0, rst = 1'b0, rdy = 1'b1, rollback = 1'b0;
    logic [5:0]  opnum = OP_NULL;
    logic [31:0] v1 = '0, v2 = '0, pc = '0, imm = '0;
    logic [3:0]  rob = '0;
    logic        valid, jump, stall;
    logic [3:0]  rob_out;
    logic [31:0] data, target;
    int          checks = 0, failures = 0;

    always #5 clk = ~clk;

    rs_ex_unit #(.OPNUM_W(6), .ROB_ID_W(4), .XLEN(32)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .opnum_from_rs(opnum),
        .V1_from_rs(v1), .V2_from_rs(v2), .pc_from_rs(pc), .imm_from_rs(imm),
        .rob_id_from_rs(rob), .rollback_sign_from_rob(rollback),
        .valid_sign_to_cdb(valid), .rob_id_to_cdb(rob_out), .data_to_cdb(data),
        .jump_sign_to_rob(jump), .target_pc_to_rob(target), .stall_sign_to_rs(stall)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] p, input logic [31:0] i, input logic [3:0] r);
        opnum = op; v1 = a; v2 = b; pc = p; imm = i; rob = r;
        step();
        opnum = OP_NULL;
    endtask

    task automatic chk_res(input string tag, input logic [3:0] r, input logic [31:0] d,
                           input logic j, input logic [31:0] t);
        chk({tag, "_valid"}, 32'(valid), 32'd1);
        chk({tag, "_rob"}, 32'(rob_out), 32'(r));
        chk({tag, "_data"}, data, d);
        chk({tag, "_jump"}, 32'(jump), 32'(j));
        chk({tag, "_target"}, target, t);
    endtask

    task automatic alu(input string tag, input logic [5:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] i, input logic [31:0] d);
        issue(op, a, b, 32'h40, i, 4'd1);
        chk_res(tag, 4'd1, d, 1'b0, 32'h44);
    endtask

    task automatic div_run(input string tag, input logic [5:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [3:0] r, input logic [31:0] d);
        int n = 0;
        issue(op, a, b, 32'h500, 32'h0, r);
        for (int i = 0; i < 40 && !valid; i++) begin
            if (stall) n++;
            if (i == 3) begin
                opnum = OP_ADD; v1 = 32'd1; v2 = 32'd1; rob = 4'd7;
            end else begin
                opnum = OP_NULL;
            end
            step();
        end
        opnum = OP_NULL;
        chk({tag, "_stall_cycles"}, 32'(n), 32'd33);
        chk_res(tag, r, d, 1'b0, 32'h504);
        chk({tag, "_stall_end"}, 32'(stall), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nv;
        step(); step();
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_rob", 32'(rob_out), 32'd0);
        chk("rst_data", data, 32'd0);
        chk("rst_jump", 32'(jump), 32'd0);
        chk("rst_target", target, 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        rst = 1'b1;
        step();

        issue(OP_ADD, 32'd5, 32'd7, 32'h40, 32'h0, 4'd3);
        chk_res("add", 4'd3, 32'd12, 1'b0, 32'h44);
        step();
        chk("add_next_valid", 32'(valid), 32'd0);
        chk("add_next_rob", 32'(rob_out), 32'd0);

        alu("sub", OP_SUB, 32'd3, 32'd5, 32'h0, 32'hFFFF_FFFE);
        alu("add_wrap", OP_ADD, 32'hFFFF_FFFF, 32'd2, 32'h0, 32'd1);
        alu("srai", OP_SRAI, 32'h8000_0000, 32'h0, 32'd4, 32'hF800_0000);
        alu("srl", OP_SRL, 32'h8000_0000, 32'h24, 32'h0, 32'h0800_0000);
        alu("sll", OP_SLL, 32'd1, 32'd33, 32'h0, 32'd2);
        alu("slt", OP_SLT, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'd1);
        alu("sltu", OP_SLTU, 32'd1, 32'hFFFF_FFFF, 32'h0, 32'd1);
        alu("sltiu", OP_SLTIU, 32'd5, 32'h0, 32'd3, 32'd0);
        alu("xori", OP_XORI, 32'hF0F0, 32'h0, 32'hFFFF, 32'h0F0F);
        alu("and", OP_AND, 32'hFF00, 32'h0FF0, 32'h0, 32'h0F00);
        alu("or", OP_OR, 32'hF000, 32'h000F, 32'h0, 32'hF00F);
        alu("lui", OP_LUI, 32'h0, 32'h0, 32'h1234_5000, 32'h1234_5000);

        issue(OP_AUIPC, 32'h0, 32'h0, 32'h1000, 32'h2000, 4'd2);
        chk_res("auipc", 4'd2, 32'h3000, 1'b0, 32'h1004);
        issue(OP_JAL, 32'h0, 32'h0, 32'h300, 32'hFFFF_FFF8, 4'd4);
        chk_res("jal", 4'd4, 32'h304, 1'b1, 32'h2F8);
        issue(OP_JALR, 32'h1001, 32'h0, 32'h200, 32'd4, 4'd5);
        chk_res("jalr", 4'd5, 32'h204, 1'b1, 32'h1004);

        issue(OP_BLT, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20, 4'd6);
        chk_res("blt", 4'd6, 32'h0, 1'b1, 32'h120);
        issue(OP_BGE, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20, 4'd6);
        chk_res("bge", 4'd6, 32'h0, 1'b0, 32'h104);
        issue(OP_BGEU, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20, 4'd6);
        chk_res("bgeu", 4'd6, 32'h0, 1'b1, 32'h120);
        issue(OP_BLTU, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20, 4'd6);
        chk_res("bltu", 4'd6, 32'h0, 1'b0, 32'h104);
        issue(OP_BEQ, 32'd4, 32'd4, 32'h100, 32'h20, 4'd6);
        chk_res("beq", 4'd6, 32'h0, 1'b1, 32'h120);
        issue(OP_BNE, 32'd4, 32'd4, 32'h100, 32'h20, 4'd6);
        chk_res("bne", 4'd6, 32'h0, 1'b0, 32'h104);

        issue(6'd63, 32'd9, 32'd9, 32'h600, 32'h8, 4'd8);
        chk_res("unknown", 4'd8, 32'h0, 1'b0, 32'h604);

        rollback = 1'b1;
        issue(OP_SUB, 32'd9, 32'd1, 32'h40, 32'h0, 4'd9);
        rollback = 1'b0;
        chk("rollback_valid", 32'(valid), 32'd0);
        chk("rollback_rob", 32'(rob_out), 32'd0);

        issue(OP_ADD, 32'h10, 32'h20, 32'h40, 32'h0, 4'd6);
        chk_res("rdy_pre", 4'd6, 32'h30, 1'b0, 32'h44);
        rdy = 1'b0;
        step();
        chk_res("rdy_hold", 4'd6, 32'h30, 1'b0, 32'h44);
        rdy = 1'b1;
        step();
        chk("rdy_release_valid", 32'(valid), 32'd0);

`ifdef RS_EX_RV32M_EN
        alu("mul", OP_MUL, 32'd6, 32'd7, 32'h0, 32'd42);
        alu("mulhu", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFE);
        alu("mulh_m1", OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0);
        alu("mulh_min", OP_MULH, 32'h8000_0000, 32'h8000_0000, 32'h0, 32'h4000_0000);
        alu("mulhsu", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF);

        div_run("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 4'd2, 32'hFFFF_FFFD);
        div_run("rem_neg", OP_REM, 32'hFFFF_FFF9, 32'd2, 4'd3, 32'hFFFF_FFFF);
        div_run("divu_zero", OP_DIVU, 32'd9, 32'd0, 4'd4, 32'hFFFF_FFFF);
        div_run("remu_zero", OP_REMU, 32'd9, 32'd0, 4'd5, 32'd9);
        div_run("div_neg_zero", OP_DIV, 32'hFFFF_FFF9, 32'd0, 4'd6, 32'hFFFF_FFFF);
        div_run("rem_neg_zero", OP_REM, 32'hFFFF_FFF9, 32'd0, 4'd7, 32'hFFFF_FFF9);
        div_run("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 4'd8, 32'h8000_0000);
        div_run("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 4'd9, 32'h0);
        div_run("divu", OP_DIVU, 32'd100, 32'd7, 4'd10, 32'd14);
        div_run("remu", OP_REMU, 32'd100, 32'd7, 4'd11, 32'd2);

        issue(OP_DIV, 32'd100, 32'd3, 32'h500, 32'h0, 4'd12);
        step(); step();
        rollback = 1'b1;
        step();
        rollback = 1'b0;
        chk("div_rollback_stall", 32'(stall), 32'd0);
        chk("div_rollback_valid", 32'(valid), 32'd0);
        nv = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (valid) nv++;
        end
        chk("div_rollback_no_bcast", 32'(nv), 32'd0);

        issue(OP_DIV, 32'd100, 32'd3, 32'h500, 32'h0, 4'd13);
        step(); step(); step();
        chk("rst_mid_pre_stall", 32'(stall), 32'd1);
`else
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'h500, 32'h0, 4'd2);
        chk_res("div_nom", 4'd2, 32'h0, 1'b0, 32'h504);
        chk("div_nom_stall", 32'(stall), 32'd0);
        issue(OP_MUL, 32'd6, 32'd7, 32'h500, 32'h0, 4'd3);
        chk_res("mul_nom", 4'd3, 32'h0, 1'b0, 32'h504);

        issue(OP_ADD, 32'd5, 32'd7, 32'h40, 32'h0, 4'd13);
        chk_res("rst_mid_pre", 4'd13, 32'd12, 1'b0, 32'h44);
`endif
        #2 rst = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(valid), 32'd0);
        chk("rst_mid_rob", 32'(rob_out), 32'd0);
        chk("rst_mid_data", data, 32'd0);
        chk("rst_mid_target", target, 32'd0);
        chk("rst_mid_stall", 32'(stall), 32'd0);
        @(posedge clk);
        #3 rst = 1'b1;
        nv = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (valid) nv++;
        end
        chk("rst_mid_no_bcast", 32'(nv), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
